mesh_terminal_port: RTL and testbench
=====================================

# mesh_terminal_port

Synthesizable terminal endpoint that attaches to one external port of the bus mesh and plays the opposite role from the router's terminal side. Toward the mesh it:
- acts as the source FIFO that the router pops: it drives `pndng_i_in` and `data_out_i_in`, and reacts to `popin`;
- acts as the sink that drains the router: it watches `pndng` and `data_out`, and drives `pop`.

A local host pushes packets for transmission and pops received packets. The sink also flags packets whose destination field does not match this terminal's coordinates. One instance sits on each of the ROWS*2+COLUMNS*2 mesh ports.

## Interface
Parameters:
- `pkg_sz`, 40: packet width in bits.
- `fifo_depth`, 4: entries in each of the TX and RX FIFOs (power of two, ≥2).
- `ROW_ID`, 0: 4-bit row coordinate of this terminal.
- `COL_ID`, 0: 4-bit column coordinate of this terminal.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `pndng_i_in` out 1: TX FIFO non-empty, presented to the mesh.
- `data_out_i_in` out pkg_sz: TX FIFO head word (first-word-fall-through).
- `popin` in 1: mesh consumes the TX head this cycle.
- `pndng` in 1: mesh has a packet for this terminal.
- `data_out` in pkg_sz: mesh packet presented with `pndng`.
- `pop` out 1: registered; this terminal consumes `data_out`.
- `tx_push` in 1 and `tx_data` in pkg_sz: host write.
- `tx_full` out 1: TX FIFO full.
- `rx_pop` in 1: host read.
- `rx_data` out pkg_sz: RX head.
- `rx_empty` out 1: RX FIFO empty.
- `misroute` out 1: one-cycle pulse when a captured packet's destination ≠ {ROW_ID, COL_ID}.
- `tx_cnt` out 16 and `rx_cnt` out 16: saturating packet counters.

## Operation
- **TX FIFO**
  - Circular buffer with read pointer, write pointer and occupancy count.
  - `pndng_i_in` = (count≠0).
  - `data_out_i_in` = mem[rd_ptr], combinational from registers.
  - `popin` while empty is ignored; the pointer does not move.
  - `tx_push` while full is dropped and the contents are unchanged.
  - Push and pop in the same cycle when non-empty: both proceed and the count is unchanged.
  - Push and pop in the same cycle when empty: the push proceeds and the pop is ignored.
- **RX drain FSM**, states IDLE, POP, SETTLE:
  - IDLE→POP when `pndng`=1 and the RX FIFO has space (count<fifo_depth). `pop` is registered high for exactly the POP cycle.
  - In POP, `data_out` is written into the RX FIFO on the closing edge, and the destination check runs on the same word.
  - POP→SETTLE unconditionally. SETTLE gives the mesh one cycle to update `pndng`/`data_out`.
  - SETTLE→IDLE unconditionally. Maximum drain rate is one packet per 3 cycles.
  - If the RX FIFO is full, the FSM stays in IDLE and `pop` stays 0. Backpressure is applied by not popping.
- **Destination check**
  - Destination row = `data_out[pkg_sz-9 -: 4]`; destination column = `data_out[pkg_sz-13 -: 4]`.
  - On a mismatch, `misroute` pulses on the cycle after the POP edge. The packet is stored anyway.
- **RX FIFO**: same structure as TX, with FWFT `rx_data`. `rx_pop` while empty is ignored. A write from POP and an `rx_pop` in the same cycle both proceed.
- **Counters**
  - `tx_cnt` increments on each accepted `popin`.
  - `rx_cnt` increments on each POP capture.
  - Both saturate at 16'hFFFF.

## Timing
- **Reset values** (`reset`=0, asynchronous):
  - All pointers and counts are 0.
  - FSM is in IDLE.
  - `pop`, `misroute`, `tx_full`, `pndng_i_in`, `tx_cnt`, `rx_cnt` are 0; `rx_empty`=1.
  - `data_out_i_in` and `rx_data` are undefined-content but are not X-propagating: the memory is cleared to 0.
- Reset deassertion is synchronous to `clk` via the flop enables. The first active edge is the first edge with `reset`=1.
- **Reset mid-operation**: an in-flight POP is abandoned and `pop` drops immediately (asynchronous). No partial write occurs.
- **TX latency**: `tx_push` at edge N → `pndng_i_in`=1 and `data_out_i_in`=tx_data after edge N.
- **RX latency**:
  - `pndng` sampled high at edge N (IDLE) → `pop`=1 during N..N+1 → data stored at edge N+1.
  - `rx_empty` falls after N+1.
  - Next earliest `pop` is after edge N+3.
- Flags `tx_full` and `rx_empty` are registered-derived from count, with no combinational path from inputs.
- Pointer wrap: at index fifo_depth-1 the pointer returns to 0. Count distinguishes full from empty when the pointers are equal.

## Test plan
- **Reset**: hold `reset`=0 with random inputs → all outputs at the listed reset values; `pop` never asserts.
- **TX ordering and full**: push 0xA1, 0xA2, 0xA3, 0xA4 → `tx_full`=1; a fifth push of 0xA5 is dropped. Pulse `popin` 4 times → `data_out_i_in` shows A1..A4 in order, then `pndng_i_in`=0 and `tx_cnt`=4.
- **Simultaneous TX push/pop at count 2**: count stays 2, order is preserved, and pointers wrap correctly across 10 cycles.
- **RX drain with correct destination**: ROW_ID=1, COL_ID=2; the mesh holds `pndng`=1 with a packet whose row field=1 and col field=2 → single-cycle `pop` pulses 3 cycles apart; `rx_data` matches; `misroute` stays 0.
- **RX backpressure and misroute**:
  - Four packets arrive with `rx_pop`=0 → after 4 captures `pop` stays 0 while `pndng`=1.
  - One `rx_pop` → the drain resumes.
  - A packet with col field=3 → `misroute` pulses for 1 cycle.
- **Reset mid-POP**: assert `reset` during the POP cycle → `pop` drops asynchronously, `rx_cnt`=0, `rx_empty`=1.

Source files
------------

// File: rtl/mesh_terminal_port.sv
// mesh_terminal_port: terminal endpoint for one external port of the bus mesh.
//
// Toward the mesh it is both the source FIFO the router pops (pndng_i_in,
// data_out_i_in, popin) and the sink that drains the router (pndng, data_out,
// pop). Toward the local host it offers a TX push port and an RX pop port.
// Captured packets whose destination field differs from {ROW_ID, COL_ID} are
// still stored, but flagged with a one-cycle misroute pulse.
//
// Ports:
//   clk, reset      : clock (rising edge), asynchronous active-low reset
//   pndng_i_in      : TX FIFO non-empty, presented to the mesh
//   data_out_i_in   : TX FIFO head word (first-word-fall-through)
//   popin           : mesh consumes the TX head this cycle
//   pndng, data_out : mesh has a packet for this terminal / that packet
//   pop             : registered; this terminal consumes data_out
//   tx_push/tx_data : host write; tx_full flags a full TX FIFO
//   rx_pop          : host read; rx_data is the RX head, rx_empty its flag
//   misroute        : one-cycle pulse for a captured packet with a foreign destination
//   tx_cnt, rx_cnt  : saturating counts of packets sent / captured

// Circular FIFO with first-word-fall-through head. Flags derive only from the
// registered occupancy count, so there is no combinational input-to-flag path.
module mesh_terminal_fifo #(
    parameter int width = 40,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
    localparam int CNT_W = $clog2(depth + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(depth - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(depth);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [width-1:0] mem [depth];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is dropped; a pop from an empty FIFO is ignored.
    // When empty, a simultaneous push still lands and the pop is ignored.
    assign do_push = push && (count != CNT_FULL);
    assign do_pop  = pop && (count != '0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the storage is cleared on reset so the head outputs never
            // carry X into the mesh before the first write.
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            end
            // Pointers alone are ambiguous when equal; the count separates full from empty.
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);
endmodule

module mesh_terminal_port #(
    parameter int pkg_sz     = 40,
    parameter int fifo_depth = 4,
    parameter int ROW_ID     = 0,
    parameter int COL_ID     = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              pndng_i_in,
    output logic [pkg_sz-1:0] data_out_i_in,
    input  logic              popin,
    input  logic              pndng,
    input  logic [pkg_sz-1:0] data_out,
    output logic              pop,
    input  logic              tx_push,
    input  logic [pkg_sz-1:0] tx_data,
    output logic              tx_full,
    input  logic              rx_pop,
    output logic [pkg_sz-1:0] rx_data,
    output logic              rx_empty,
    output logic              misroute,
    output logic [15:0]       tx_cnt,
    output logic [15:0]       rx_cnt
);
    localparam logic [3:0]  MY_ROW  = 4'(ROW_ID);
    localparam logic [3:0]  MY_COL  = 4'(COL_ID);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_SETTLE
    } drain_state_t;

    drain_state_t state;
    drain_state_t next_state;
    logic         tx_empty;
    logic         rx_full;
    logic         capture;
    logic         tx_accept;
    logic         dest_mismatch;

    mesh_terminal_fifo #(.width(pkg_sz), .depth(fifo_depth)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (tx_data),
        .pop       (popin),
        .head      (data_out_i_in),
        .empty     (tx_empty),
        .full      (tx_full)
    );

    mesh_terminal_fifo #(.width(pkg_sz), .depth(fifo_depth)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data (data_out),
        .pop       (rx_pop),
        .head      (rx_data),
        .empty     (rx_empty),
        .full      (rx_full)
    );

    assign pndng_i_in = !tx_empty;
    assign tx_accept  = popin && !tx_empty;

    // The word on data_out is taken on the edge that closes the POP cycle.
    assign capture = (state == ST_POP);

    assign dest_mismatch = {data_out[pkg_sz-9 -: 4], data_out[pkg_sz-13 -: 4]} != {MY_ROW, MY_COL};

    // Drain sequence IDLE -> POP -> SETTLE -> IDLE; SETTLE gives the mesh one
    // cycle to present its next packet before pndng is trusted again. A full
    // RX FIFO holds the FSM in IDLE, which is the only backpressure applied.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            ST_IDLE:   if (pndng && !rx_full) next_state = ST_POP;
            ST_POP:    next_state = ST_SETTLE;
            ST_SETTLE: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            pop      <= 1'b0;
            misroute <= 1'b0;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
        end else begin
            state    <= next_state;
            pop      <= (next_state == ST_POP);
            misroute <= capture && dest_mismatch;
            if (tx_accept && (tx_cnt != CNT_MAX)) begin
                tx_cnt <= tx_cnt + 16'd1;
            end
            if (capture && (rx_cnt != CNT_MAX)) begin
                rx_cnt <= rx_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mesh_terminal_port.sv
// tb_mesh_terminal_port: directed bench for mesh_terminal_port (ROW_ID=1, COL_ID=2).
// A queue-based model tracks the TX/RX contents, the counters, and the drain
// timing rule "at most one pop start every three edges, captured one edge
// later"; a negedge process compares every output against it each cycle.
// Literal expectations in the stimulus pin down the model itself.
module tb_mesh_terminal_port;
    localparam int PKG   = 40;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           pndng_i_in;
    logic [PKG-1:0] data_out_i_in;
    logic           popin = 1'b0;
    logic           pndng = 1'b0;
    logic [PKG-1:0] data_out = '0;
    logic           pop;
    logic           tx_push = 1'b0;
    logic [PKG-1:0] tx_data = '0;
    logic           tx_full;
    logic           rx_pop = 1'b0;
    logic [PKG-1:0] rx_data;
    logic           rx_empty;
    logic           misroute;
    logic [15:0]    tx_cnt;
    logic [15:0]    rx_cnt;

    mesh_terminal_port #(
        .pkg_sz     (PKG),
        .fifo_depth (DEPTH),
        .ROW_ID     (1),
        .COL_ID     (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pndng_i_in    (pndng_i_in),
        .data_out_i_in (data_out_i_in),
        .popin         (popin),
        .pndng         (pndng),
        .data_out      (data_out),
        .pop           (pop),
        .tx_push       (tx_push),
        .tx_data       (tx_data),
        .tx_full       (tx_full),
        .rx_pop        (rx_pop),
        .rx_data       (rx_data),
        .rx_empty      (rx_empty),
        .misroute      (misroute),
        .tx_cnt        (tx_cnt),
        .rx_cnt        (rx_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [PKG-1:0] m_tx[$];
    logic [PKG-1:0] m_rx[$];
    int             m_tx_cnt = 0;
    int             m_rx_cnt = 0;
    bit             m_pop = 0;
    bit             m_misroute = 0;
    int             cyc = 0;
    int             last_start = -100;
    bit             m_capture;
    bit             m_start;

    function automatic bit is_misrouted(input logic [PKG-1:0] p);
        return (p[PKG-9 -: 4] != 4'd1) || (p[PKG-13 -: 4] != 4'd2);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_tx.delete();
            m_rx.delete();
            m_tx_cnt   = 0;
            m_rx_cnt   = 0;
            m_pop      = 0;
            m_misroute = 0;
            cyc        = 0;
            last_start = -100;
        end else begin
            m_capture = (cyc == last_start + 1);
            m_start   = (cyc >= last_start + 3) && pndng && (m_rx.size() < DEPTH);
            // TX: acceptance is judged on the occupancy before this edge.
            if (popin && m_tx.size() > 0) begin
                if (tx_push && m_tx.size() < DEPTH) m_tx.push_back(tx_data);
                void'(m_tx.pop_front());
                if (m_tx_cnt < 65535) m_tx_cnt++;
            end else if (tx_push && m_tx.size() < DEPTH) begin
                m_tx.push_back(tx_data);
            end
            // RX: host read first, then the captured word goes to the tail.
            if (rx_pop && m_rx.size() > 0) void'(m_rx.pop_front());
            if (m_capture) begin
                m_rx.push_back(data_out);
                if (m_rx_cnt < 65535) m_rx_cnt++;
            end
            m_misroute = m_capture && is_misrouted(data_out);
            if (m_start) last_start = cyc;
            m_pop = m_start;
            cyc++;
        end
    end

    always @(negedge clk) begin
        check("pop", pop, m_pop);
        check("misroute", misroute, m_misroute);
        check("pndng_i_in", pndng_i_in, m_tx.size() != 0);
        check("tx_full", tx_full, m_tx.size() == DEPTH);
        check("rx_empty", rx_empty, m_rx.size() == 0);
        check("tx_cnt", tx_cnt, 64'(m_tx_cnt));
        check("rx_cnt", rx_cnt, 64'(m_rx_cnt));
        if (m_tx.size() > 0) check("tx_head", data_out_i_in, m_tx[0]);
        if (m_rx.size() > 0) check("rx_head", rx_data, m_rx[0]);
    end

    // ---------------- mesh source emulation ----------------
    logic [PKG-1:0] mesh_q[$];
    bit             pop_seen;
    int             pop_pulses = 0;
    int             mis_seen = 0;

    task automatic mesh_drive();
        pndng    = (mesh_q.size() > 0);
        data_out = (mesh_q.size() > 0) ? mesh_q[0] : '0;
    endtask

    // One clock: sample pop/misroute mid-cycle, then advance the mesh after a pop edge.
    task automatic step();
        @(negedge clk);
        pop_seen = pop;
        if (pop) pop_pulses++;
        if (misroute) mis_seen++;
        @(posedge clk);
        #1;
        if (pop_seen && mesh_q.size() > 0) void'(mesh_q.pop_front());
        mesh_drive();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    logic [PKG-1:0] exp_a [4];
    logic [PKG-1:0] good_p [3];
    bit             found;

    initial begin
        exp_a  = '{40'h00000000A1, 40'h00000000A2, 40'h00000000A3, 40'h00000000A4};
        good_p = '{40'h0012000001, 40'h0012000002, 40'h0012000003};

        // ---- reset held with random inputs ----
        reset = 1'b0;
        repeat (6) begin
            popin    = 1'($urandom);
            pndng    = 1'($urandom);
            data_out = {8'($urandom), 32'($urandom)};
            tx_push  = 1'($urandom);
            tx_data  = {8'($urandom), 32'($urandom)};
            rx_pop   = 1'($urandom);
            @(posedge clk);
            #1;
        end
        check("rst_pop", pop, 1'b0);
        check("rst_rx_empty", rx_empty, 1'b1);
        check("rst_tx_full", tx_full, 1'b0);
        check("rst_pndng_i_in", pndng_i_in, 1'b0);
        check("rst_tx_cnt", tx_cnt, 16'd0);
        check("rst_rx_cnt", rx_cnt, 16'd0);
        check("rst_misroute", misroute, 1'b0);
        check("rst_tx_head", data_out_i_in, 40'd0);
        check("rst_rx_head", rx_data, 40'd0);
        popin = 0; pndng = 0; data_out = '0; tx_push = 0; tx_data = '0; rx_pop = 0;
        reset = 1'b1;

        // ---- TX ordering and full ----
        for (int i = 0; i < 4; i++) begin
            tx_push = 1'b1;
            tx_data = exp_a[i];
            step();
        end
        check("tx_full_after4", tx_full, 1'b1);
        tx_data = 40'h00000000A5;
        step();
        tx_push = 1'b0;
        check("tx_full_after5", tx_full, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("tx_order", data_out_i_in, exp_a[i]);
            popin = 1'b1;
            step();
            popin = 1'b0;
            step();
        end
        check("tx_drained", pndng_i_in, 1'b0);
        check("tx_cnt_4", tx_cnt, 16'd4);

        // ---- simultaneous push/pop at count 2 ----
        tx_push = 1'b1;
        tx_data = 40'h00000000B0;
        step();
        tx_data = 40'h00000000B1;
        step();
        popin = 1'b1;
        for (int i = 2; i < 12; i++) begin
            tx_data = 40'h00000000B0 + 40'(i);
            step();
            check("tx_pushpop_head", data_out_i_in, 40'h00000000B0 + 40'(i - 1));
            check("tx_pushpop_notfull", tx_full, 1'b0);
        end
        tx_push = 1'b0;
        step();
        check("tx_tail_head", data_out_i_in, 40'h00000000BB);
        step();
        popin = 1'b0;
        check("tx_empty_again", pndng_i_in, 1'b0);
        check("tx_cnt_16", tx_cnt, 16'd16);

        // ---- RX drain, correct destination ----
        pop_pulses = 0;
        mis_seen   = 0;
        for (int i = 0; i < 3; i++) mesh_q.push_back(good_p[i]);
        mesh_drive();
        repeat (12) step();
        check("rx_pop_pulses_3", 64'(pop_pulses), 64'd3);
        check("rx_no_misroute", 64'(mis_seen), 64'd0);
        check("rx_cnt_3", rx_cnt, 16'd3);
        check("mesh_drained", 64'(mesh_q.size()), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("rx_order", rx_data, good_p[i]);
            rx_pop = 1'b1;
            step();
            rx_pop = 1'b0;
        end
        check("rx_empty_after_read", rx_empty, 1'b1);

        // ---- RX backpressure, then misroute ----
        pop_pulses = 0;
        mis_seen   = 0;
        mesh_q.push_back(40'h0012000011);
        mesh_q.push_back(40'h0012000012);
        mesh_q.push_back(40'h0012000013);
        mesh_q.push_back(40'h0012000014);
        mesh_q.push_back(40'h0013000099);
        mesh_drive();
        repeat (20) step();
        check("bp_pop_pulses_4", 64'(pop_pulses), 64'd4);
        check("bp_pop_low", pop, 1'b0);
        check("bp_mesh_left", 64'(mesh_q.size()), 64'd1);
        check("bp_rx_cnt_7", rx_cnt, 16'd7);
        check("bp_rx_head", rx_data, 40'h0012000011);
        rx_pop = 1'b1;
        step();
        rx_pop = 1'b0;
        check("bp_rx_head_next", rx_data, 40'h0012000012);
        repeat (8) step();
        check("bp_pop_pulses_5", 64'(pop_pulses), 64'd5);
        check("misroute_pulses_1", 64'(mis_seen), 64'd1);
        check("bp_rx_cnt_8", rx_cnt, 16'd8);
        check("bp_mesh_empty", 64'(mesh_q.size()), 64'd0);

        // ---- reset during the POP cycle ----
        mesh_q.push_back(40'h0012000077);
        mesh_drive();
        rx_pop = 1'b1;
        step();
        rx_pop = 1'b0;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(posedge clk);
            #1;
            if (pop === 1'b1) found = 1;
        end
        check("pop_wait", found, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("midpop_pop", pop, 1'b0);
        check("midpop_rx_cnt", rx_cnt, 16'd0);
        check("midpop_rx_empty", rx_empty, 1'b1);
        check("midpop_tx_cnt", tx_cnt, 16'd0);
        mesh_q.delete();
        mesh_drive();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        repeat (4) step();
        check("post_reset_rx_empty", rx_empty, 1'b1);
        check("post_reset_rx_cnt", rx_cnt, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
